// File: rtl/proc_checkpoint_monitor.sv
// proc_checkpoint_monitor: self-check monitor that sits beside the single-cycle
// core. It compares MemtoRegOut against a table of (PC threshold, expected value)
// checkpoints, counts passes/failures and aborts runaway programs via a watchdog.
// Ports: CLK/reset (sync, active-high); cfg_* table load (IDLE only), cfg_count
// sampled on start; currentpc/MemtoRegOut observed core buses; busy/done/timeout/
// all_pass status; pass_count/fail_count saturating counters; chk_idx next entry;
// fail_idx/fail_actual first-failure capture (only when CHKMON_FAIL_CAPTURE_EN is
// defined, otherwise tied to 0). All outputs come from registers.
module proc_checkpoint_monitor #(
  parameter int NUM_CHK    = 4,
  parameter int DATA_W     = 64,
  parameter int PC_W       = 64,
  parameter int WDOG_W     = 16,
  parameter int WDOG_LIMIT = 255,
  localparam int IDX_W     = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
  localparam int CNT_W     = IDX_W + 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [PC_W-1:0]   cfg_pc,
  input  logic [DATA_W-1:0] cfg_expect,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              start,
  input  logic [PC_W-1:0]   currentpc,
  input  logic [DATA_W-1:0] MemtoRegOut,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              all_pass,
  output logic [7:0]        pass_count,
  output logic [7:0]        fail_count,
  output logic [CNT_W-1:0]  chk_idx,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [DATA_W-1:0] fail_actual
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Checkpoint table: deliberately not reset so a program can be re-run after reset.
  logic [PC_W-1:0]   tbl_pc  [NUM_CHK];
  logic [DATA_W-1:0] tbl_exp [NUM_CHK];

  logic [CNT_W-1:0]  cnt_q;
  logic [WDOG_W-1:0] wdog;
  logic [IDX_W-1:0]  cur_idx;
  logic              hit;
  logic              match;
  logic              last;
  logic              wdog_exp;
  logic              arm;

  always_ff @(posedge CLK) begin
    if (cfg_we && state == IDLE && 32'(cfg_idx) < NUM_CHK) begin
      tbl_pc[cfg_idx]  <= cfg_pc;
      tbl_exp[cfg_idx] <= cfg_expect;
    end
  end

  // chk_idx stays below cnt_q while in RUN, so its low bits address the table.
  assign cur_idx  = chk_idx[IDX_W-1:0];
  assign hit      = (state == RUN) && (currentpc >= tbl_pc[cur_idx]);
  assign match    = (MemtoRegOut == tbl_exp[cur_idx]);
  assign last     = hit && (chk_idx == cnt_q - CNT_W'(1));
  assign wdog_exp = (state == RUN) && (wdog == WDOG_W'(WDOG_LIMIT - 1));
  assign arm      = start && (state != RUN);

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      // Completing the last checkpoint takes priority over an expiring watchdog.
      RUN:     if (last) state_nxt = DONE;
               else if (wdog_exp) state_nxt = TIMEOUT;
      DONE,
      TIMEOUT: if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q      <= '0;
      wdog       <= '0;
      chk_idx    <= '0;
      pass_count <= '0;
      fail_count <= '0;
    end else if (arm) begin
      cnt_q      <= cfg_count;
      wdog       <= '0;
      chk_idx    <= '0;
      pass_count <= '0;
      fail_count <= '0;
    end else if (state == RUN) begin
      wdog <= wdog + WDOG_W'(1);
      if (hit) begin
        chk_idx <= chk_idx + CNT_W'(1);
        if (match) begin
          if (pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
        end else begin
          if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
        end
      end
    end
  end

`ifdef CHKMON_FAIL_CAPTURE_EN
  // fail_count only leaves zero on the first failure (it saturates, never wraps).
  always_ff @(posedge CLK) begin
    if (reset || arm) begin
      fail_idx    <= '0;
      fail_actual <= '0;
    end else if (hit && !match && fail_count == 8'd0) begin
      fail_idx    <= cur_idx;
      fail_actual <= MemtoRegOut;
    end
  end
`else
  assign fail_idx    = '0;
  assign fail_actual = '0;
`endif

  assign busy     = (state == RUN);
  assign done     = (state == DONE) || (state == TIMEOUT);
  assign timeout  = (state == TIMEOUT);
  assign all_pass = (state == DONE) && (fail_count == 8'd0) && (pass_count == 8'(cnt_q));

endmodule

// File: tb/tb_proc_checkpoint_monitor.sv
module tb_proc_checkpoint_monitor;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [63:0] cfg_pc = '0;
  logic [63:0] cfg_expect = '0;
  logic [2:0]  cfg_count = '0;
  logic        start = 1'b0;
  logic [63:0] currentpc = '0;
  logic [63:0] MemtoRegOut = '0;
  logic        busy, done, timeout, all_pass;
  logic [7:0]  pass_count, fail_count;
  logic [2:0]  chk_idx;
  logic [1:0]  fail_idx;
  logic [63:0] fail_actual;

  int errs = 0;
  int checks = 0;

  proc_checkpoint_monitor #(
    .NUM_CHK(4), .DATA_W(64), .PC_W(64), .WDOG_W(16), .WDOG_LIMIT(255)
  ) dut (
    .CLK(CLK), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc),
    .cfg_expect(cfg_expect), .cfg_count(cfg_count), .start(start),
    .currentpc(currentpc), .MemtoRegOut(MemtoRegOut), .busy(busy), .done(done),
    .timeout(timeout), .all_pass(all_pass), .pass_count(pass_count),
    .fail_count(fail_count), .chk_idx(chk_idx), .fail_idx(fail_idx),
    .fail_actual(fail_actual)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [1:0] idx, input logic [63:0] pc, input logic [63:0] exp);
    cfg_we = 1'b1; cfg_idx = idx; cfg_pc = pc; cfg_expect = exp;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] cnt);
    cfg_count = cnt; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic b, input logic d,
                              input logic t, input logic ap);
    check({tag, ".busy"}, 64'(busy), 64'(b));
    check({tag, ".done"}, 64'(done), 64'(d));
    check({tag, ".timeout"}, 64'(timeout), 64'(t));
    check({tag, ".all_pass"}, 64'(all_pass), 64'(ap));
  endtask

  // Walks PC 0..0x54 step 4; bad_first drives 0xE instead of 0xF at PC 0x30.
  task automatic run_prog(input logic bad_first);
    for (int pc = 0; pc <= 'h54; pc += 4) begin
      currentpc = 64'(pc);
      if (pc == 'h30)      MemtoRegOut = bad_first ? 64'hE : 64'hF;
      else if (pc == 'h54) MemtoRegOut = 64'h1234_5678_9ABC_DEF0;
      else                 MemtoRegOut = 64'h0;
      tick();
      if (pc == 'h30) begin
        check("prog.chk_idx_after_first", 64'(chk_idx), 64'd1);
        check("prog.busy_after_first", 64'(busy), 64'd1);
      end
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.pass", 64'(pass_count), 64'd0);
    check("rst.fail", 64'(fail_count), 64'd0);
    check("rst.chk_idx", 64'(chk_idx), 64'd0);
    check("rst.fail_idx", 64'(fail_idx), 64'd0);
    check("rst.fail_actual", fail_actual, 64'd0);

    // Pass run
    load(2'd0, 64'h30, 64'hF);
    load(2'd1, 64'h54, 64'h1234_5678_9ABC_DEF0);
    currentpc = 64'h0;
    do_start(3'd2);
    check_status("pass.start", 1'b1, 1'b0, 1'b0, 1'b0);
    run_prog(1'b0);
    check_status("pass.end", 1'b0, 1'b1, 1'b0, 1'b1);
    check("pass.pass", 64'(pass_count), 64'd2);
    check("pass.fail", 64'(fail_count), 64'd0);

    // Mismatch, re-armed from DONE
    currentpc = 64'h0;
    do_start(3'd2);
    check("mis.pass_cleared", 64'(pass_count), 64'd0);
    check("mis.chk_cleared", 64'(chk_idx), 64'd0);
    run_prog(1'b1);
    check_status("mis.end", 1'b0, 1'b1, 1'b0, 1'b0);
    check("mis.pass", 64'(pass_count), 64'd1);
    check("mis.fail", 64'(fail_count), 64'd1);
    check("mis.fail_idx", 64'(fail_idx), 64'd0);
`ifdef CHKMON_FAIL_CAPTURE_EN
    check("mis.fail_actual", fail_actual, 64'hE);
`else
    check("mis.fail_actual", fail_actual, 64'h0);
`endif

    // Watchdog: threshold 0x30, PC parked at 0x10
    do_reset();
    currentpc = 64'h10; MemtoRegOut = 64'hF;
    do_start(3'd1);
    for (int i = 1; i <= 254; i++) tick();
    check_status("wd.edge254", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_status("wd.edge255", 1'b0, 1'b1, 1'b1, 1'b0);
    check("wd.pass", 64'(pass_count), 64'd0);
    check("wd.chk_idx", 64'(chk_idx), 64'd0);

    // Table write outside IDLE is ignored: entry 0 stays at threshold 0x30
    load(2'd0, 64'h0, 64'h0);
    do_start(3'd1);
    tick();
    check("wr_ign.chk_idx", 64'(chk_idx), 64'd0);
    currentpc = 64'h30;
    tick();
    check_status("wr_ign.end", 1'b0, 1'b1, 1'b0, 1'b1);
    check("wr_ign.pass", 64'(pass_count), 64'd1);

    // PC skip past three thresholds
    do_reset();
    load(2'd0, 64'h10, 64'hAA);
    load(2'd1, 64'h20, 64'hAA);
    load(2'd2, 64'h30, 64'hAA);
    currentpc = 64'h0;
    do_start(3'd3);
    currentpc = 64'h40; MemtoRegOut = 64'hAA;
    tick();
    check("skip.pass1", 64'(pass_count), 64'd1);
    check("skip.done1", 64'(done), 64'd0);
    tick();
    check("skip.pass2", 64'(pass_count), 64'd2);
    check("skip.chk2", 64'(chk_idx), 64'd2);
    tick();
    check("skip.pass3", 64'(pass_count), 64'd3);
    check_status("skip.end", 1'b0, 1'b1, 1'b0, 1'b1);

    // Simultaneous: last checkpoint hits on the 255th RUN edge
    currentpc = 64'h0;
    do_start(3'd1);
    for (int i = 1; i <= 254; i++) tick();
    check("sim.busy254", 64'(busy), 64'd1);
    currentpc = 64'h10; MemtoRegOut = 64'hAA;
    tick();
    check_status("sim.end", 1'b0, 1'b1, 1'b0, 1'b1);
    check("sim.pass", 64'(pass_count), 64'd1);

    // Reset mid-run after one pass; start during RUN is ignored
    currentpc = 64'h10; MemtoRegOut = 64'hAA;
    do_start(3'd3);
    tick();
    check("mid.pass1", 64'(pass_count), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mid.start_ignored", 64'(pass_count), 64'd1);
    check("mid.chk_kept", 64'(chk_idx), 64'd1);
    do_reset();
    check_status("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid.rst_pass", 64'(pass_count), 64'd0);
    check("mid.rst_fail", 64'(fail_count), 64'd0);
    check("mid.rst_chk", 64'(chk_idx), 64'd0);
    currentpc = 64'h40;
    do_start(3'd3);
    tick(); tick(); tick();
    check_status("mid.rerun", 1'b0, 1'b1, 1'b0, 1'b1);
    check("mid.rerun_pass", 64'(pass_count), 64'd3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/proc_checkpoint_monitor.md
# proc_checkpoint_monitor

- Synthesizable, parametrised self-check monitor for the single-cycle processor.
- Watches `currentpc` and `MemtoRegOut` and compares the result value against a loaded table of up to NUM_CHK (PC threshold, expected value) checkpoints.
- Counts passes and failures and kills runaway programs with a configurable watchdog.
- Sits beside the `singlecycle` core and replaces hand-written per-program PC polling loops, both in simulation benches and in on-FPGA regression.

## Interface

- NUM_CHK, 4, number of checkpoint table entries (1..16).
- DATA_W, 64, width of the result bus and expected values.
- PC_W, 64, width of the PC bus and thresholds.
- WDOG_W, 16, width of the watchdog counter.
- WDOG_LIMIT, 255, cycle count in RUN at which the watchdog expires (must be < 2^WDOG_W).
- CLK  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  checkpoint table write strobe; honoured only in IDLE.
- cfg_idx  in  clog2(NUM_CHK)  table entry index.
- cfg_pc  in  PC_W  PC threshold for entry cfg_idx.
- cfg_expect  in  DATA_W  expected `MemtoRegOut` for entry cfg_idx.
- cfg_count  in  clog2(NUM_CHK)+1  number of active entries (1..NUM_CHK); sampled on start.
- start  in  1  single-cycle pulse; IDLE→RUN.
- currentpc  in  PC_W  core PC.
- MemtoRegOut  in  DATA_W  core write-back value.
- busy  out  1  high in RUN.
- done  out  1  high in DONE or TIMEOUT.
- timeout  out  1  high in TIMEOUT.
- all_pass  out  1  high in DONE when fail_count==0 and pass_count==active count.
- pass_count, fail_count  out  8 each  saturating result counters.
- chk_idx  out  clog2(NUM_CHK)+1  index of the next checkpoint to evaluate.
- fail_idx  out  clog2(NUM_CHK)  index of the first failing entry.
- fail_actual  out  DATA_W  `MemtoRegOut` captured at the first failure.

## Operation

- States:
  - IDLE(0): table writable.
  - RUN(1)
  - DONE(2)
  - TIMEOUT(3)
- Transitions:
  - IDLE + start → RUN. Latches cfg_count and clears the counters, chk_idx, watchdog and capture registers.
  - In RUN, each cycle, when currentpc >= table[chk_idx].pc (unsigned compare), the checkpoint is evaluated:
    - MemtoRegOut == expect → pass_count+1.
    - Otherwise fail_count+1, and on the first failure fail_idx and fail_actual are captured.
    - chk_idx then increments.
  - At most one checkpoint is evaluated per cycle. If the PC jumps past several thresholds, the remaining ones are evaluated on following cycles using the then-current bus values.
  - RUN → DONE on the cycle the last active entry (chk_idx == count-1) is evaluated.
  - The watchdog increments every RUN cycle. RUN → TIMEOUT when watchdog == WDOG_LIMIT-1 at an edge, unless the DONE condition occurs in the same cycle; DONE wins.
  - DONE/TIMEOUT + start → RUN (re-arm); otherwise hold.
- start while in RUN is ignored. cfg_we outside IDLE is ignored; the table is unchanged.
- Counters saturate at 255.
- Reset:
  - State IDLE; all outputs 0; watchdog 0.
  - Table contents are retained (not reset).
  - Reset mid-RUN aborts the run with no partial result.

## Timing

- Checkpoint evaluation uses the values present at rising edge N. The counters, chk_idx and capture registers update at edge N. done/all_pass are visible after edge N (registered, one-cycle latency from the evaluating edge).
- A table write at edge N is usable by a start at edge N+1.
- The watchdog first counts at the edge after the start edge. TIMEOUT is entered at the WDOG_LIMIT-th RUN edge.
- All outputs are registered; there are no combinational paths from the inputs to the outputs.

## Configuration

- `CHKMON_FAIL_CAPTURE_EN`
  - Defined: fail_idx/fail_actual registers are implemented as described.
  - Undefined: both outputs are tied to 0 and their registers are removed. Counting, state and timeout behaviour are unchanged.

## Test plan

- Pass run:
  - Load {0x30→0xF, 0x54→0x123456789ABCDEF0}, cfg_count=2, start.
  - Drive PC 0,4,…,0x54 with matching values at the thresholds.
  - Required: pass_count=2, fail_count=0, all_pass=1, done=1, timeout=0.
- Mismatch:
  - Same table; drive 0xE at PC 0x30.
  - Required: fail_count=1, fail_idx=0, fail_actual=0xE, all_pass=0 (with the macro); fail_actual=0 (without it).
- Watchdog:
  - WDOG_LIMIT=255, PC held at 0x10, threshold 0x30.
  - Required: timeout=1 exactly 255 cycles after start; pass_count=0.
- PC skip:
  - Thresholds {0x10,0x20,0x30}; PC jumps 0x0→0x40 with value 0xAA, all expects 0xAA.
  - Required: three passes on three consecutive cycles, then DONE.
- Simultaneous:
  - Last checkpoint matches on the same edge the watchdog hits its limit.
  - Required: DONE, timeout=0.
- Reset mid-run:
  - Assert reset during RUN after one pass.
  - Required: IDLE, all counters 0.
  - A restart with the retained table passes the program again.
